// File: rtl/odev1_scan.sv
// Truth-table scanner: steps {a,b,c,d} through all 16 input vectors, waits
// SETTLE_CYCLES per vector, then captures f into table_out and counts the ones.
module odev1_scan #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones_count
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_e;

    // The counter runs from SETTLE_CYCLES-1 down to 0, giving SETTLE_CYCLES APPLY cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  settle_q, settle_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  ones_q, ones_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        table_d  = table_q;
        ones_d   = ones_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = APPLY;
                    idx_d    = 4'd0;
                    table_d  = 16'h0000;
                    ones_d   = 5'd0;
                    settle_d = SETTLE_LOAD;
                end
            end
            APPLY: begin
                busy = 1'b1;
                if (settle_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            SAMPLE: begin
                busy           = 1'b1;
                table_d[idx_q] = f;
                ones_d         = ones_q + 5'(f);
                // idx saturates at 15 so the vector outputs stay put through DONE.
                if (idx_q == 4'd15) begin
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q + 4'd1;
                    settle_d = SETTLE_LOAD;
                    state_d  = APPLY;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            settle_q <= 4'd0;
            table_q  <= 16'h0000;
            ones_q   <= 5'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            table_q  <= table_d;
            ones_q   <= ones_d;
        end
    end

    // Vector outputs come straight from flops, so they only move at clock edges.
    assign {a, b, c, d} = idx_q;
    assign table_out    = table_q;
    assign ones_count   = ones_q;

endmodule

// File: tb/tb_odev1_scan.sv
// Self-checking bench for odev1_scan: two instances (default settle and settle=3)
// driven by a lookup-table function stage, checked cycle by cycle against a timeline model.
module tb_odev1_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1;
    logic [15:0] lut;

    logic        a0, b0, c0, d0, busy0, done0, f0;
    logic [15:0] tbl0;
    logic [4:0]  ones0;
    logic        a1, b1, c1, d1, busy1, done1, f1;
    logic [15:0] tbl1;
    logic [4:0]  ones1;

    // Function stage: purely combinational lookup of the current vector.
    assign f0 = lut[{a0, b0, c0, d0}];
    assign f1 = lut[{a1, b1, c1, d1}];

    odev1_scan u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .f(f0),
        .a(a0), .b(b0), .c(c0), .d(d0),
        .busy(busy0), .done(done0), .table_out(tbl0), .ones_count(ones0)
    );

    odev1_scan #(.SETTLE_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .f(f1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .table_out(tbl1), .ones_count(ones1)
    );

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic [3:0]  vec;
    logic        busy_o, done_o;
    logic [15:0] tbl_o;
    logic [4:0]  ones_o;

    always_comb begin
        if (sel == 1) begin
            vec = {a1, b1, c1, d1}; busy_o = busy1; done_o = done1; tbl_o = tbl1; ones_o = ones1;
        end else begin
            vec = {a0, b0, c0, d0}; busy_o = busy0; done_o = done0; tbl_o = tbl0; ones_o = ones0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] formula_lut();
        logic [15:0] t;
        logic fa, fb, fc, fd;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            fa = i[3]; fb = i[2]; fc = i[1]; fd = i[0];
            t[i] = ~((~fa & fb) | (fb & fc)) | (fa & ~fd) | (fb & fd);
        end
        return t;
    endfunction

    task automatic set_start(input logic v);
        if (sel == 1) start1 = v;
        else          start0 = v;
    endtask

    // Expected table after n vectors have been sampled.
    function automatic logic [15:0] partial(input int n);
        logic [16:0] mask;
        mask = (17'h1 << n) - 17'h1;
        return lut & mask[15:0];
    endfunction

    // One full scan; vector i is applied from edge i*(s+1) and sampled on edge (i+1)*(s+1).
    task automatic run_scan(input int s, input bit disturb);
        int total;
        int n;
        logic [15:0] exp;
        total = 16 * (s + 1);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        check("start_vec",  vec,    32'd0);
        check("start_busy", busy_o, 32'd1);
        check("start_tbl",  tbl_o,  32'd0);
        check("start_ones", ones_o, 32'd0);
        for (int k = 1; k <= total + 1; k++) begin
            if (disturb && (k == 5 || k == 20)) set_start(1'b1);
            @(posedge clk); #1;
            set_start(1'b0);
            if (k < total) begin
                n   = k / (s + 1);
                exp = partial(n);
                check("scan_vec",  vec,    n);
                check("scan_busy", busy_o, 32'd1);
                check("scan_done", done_o, 32'd0);
                check("scan_tbl",  tbl_o,  exp);
                check("scan_ones", ones_o, $countones(exp));
            end else if (k == total) begin
                check("done_pulse", done_o, 32'd1);
                check("done_busy",  busy_o, 32'd0);
                check("done_vec",   vec,    32'd15);
                check("done_tbl",   tbl_o,  lut);
                check("done_ones",  ones_o, $countones(lut));
            end else begin
                check("idle_done", done_o, 32'd0);
                check("idle_busy", busy_o, 32'd0);
                check("idle_tbl",  tbl_o,  lut);
            end
        end
    endtask

    initial begin
        bit seen_done;
        logic [15:0] keep;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 0;
        lut = formula_lut();
        #12;
        check("rst_vec",  vec,    32'd0);
        check("rst_busy", busy_o, 32'd0);
        check("rst_done", done_o, 32'd0);
        check("rst_tbl",  tbl_o,  32'd0);
        check("rst_ones", ones_o, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("wait_idle", busy_o, 32'd0);

        // Reference function.
        run_scan(1, 1'b0);
        check("formula_tbl",  tbl_o,  32'hFFAF);
        check("formula_ones", ones_o, 32'd14);

        // Constant functions: no ones, then all ones without overflow.
        lut = 16'h0000;
        run_scan(1, 1'b0);
        check("zero_tbl", tbl_o, 32'h0000);
        lut = 16'hFFFF;
        run_scan(1, 1'b0);
        check("ones_tbl",  tbl_o,  32'hFFFF);
        check("ones_cnt",  ones_o, 32'd16);

        // Longer settle on the second instance.
        sel = 1;
        lut = formula_lut();
        run_scan(3, 1'b0);
        sel = 0;

        // Start pulses mid-scan must be ignored.
        lut = 16'($urandom);
        run_scan(1, 1'b1);

        for (int r = 0; r < 3; r++) begin
            lut = 16'($urandom);
            run_scan(1, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a scan.
        lut = 16'($urandom) | 16'h0001;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_vec",  vec,    32'd0);
        check("abort_busy", busy_o, 32'd0);
        check("abort_done", done_o, 32'd0);
        check("abort_tbl",  tbl_o,  32'd0);
        check("abort_ones", ones_o, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) seen_done = 1'b1;
        end
        check("abort_quiet", seen_done, 32'd0);
        lut = 16'($urandom);
        run_scan(1, 1'b0);

        // Start held high: two back-to-back scans.
        lut = 16'($urandom) | 16'h8000;
        keep = lut;
        start0 = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 68; k++) begin
            @(posedge clk); #1;
            check("b2b_done", done_o, (k == 32 || k == 66) ? 32'd1 : 32'd0);
            if (k == 33) begin
                check("b2b_idle_busy", busy_o, 32'd0);
                check("b2b_first_tbl", tbl_o,  keep);
            end
            if (k == 34) begin
                check("b2b_restart_busy", busy_o, 32'd1);
                check("b2b_clear_tbl",    tbl_o,  32'd0);
                check("b2b_clear_ones",   ones_o, 32'd0);
            end
            if (k == 66) start0 = 1'b0;
            if (k == 68) begin
                check("b2b_end_busy", busy_o, 32'd0);
                check("b2b_end_tbl",  tbl_o,  keep);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/odev1_scan.md
ODEV1_SCAN -- requirements
Module: odev1_scan

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of cycles each input vector is held before f is sampled; the legal range SHALL be 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin a scan; it SHALL be sampled only in IDLE.
REQ-005 The block SHALL have port f, input, 1 bit: the result from the downstream combinational function stage (a,b,c,d -> f).
REQ-006 The block SHALL have ports a, b, c, d, each an output of 1 bit, driving the inputs of the function stage.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a scan completes.
REQ-009 The block SHALL have port table_out, output, 16 bits: the captured truth table, where bit i is f sampled for vector index i.
REQ-010 The block SHALL have port ones_count, output, 5 bits: the number of 1s captured in the current or last scan (0..16).

Function
REQ-011 A 4-bit vector index idx SHALL drive {a,b,c,d} = idx[3:0] from registers, with a as the MSB; the outputs SHALL be glitch-free and change only at clock edges.
REQ-012 The FSM SHALL have the states IDLE, APPLY, SAMPLE and DONE.
REQ-013 IDLE with start=1 at a clock edge SHALL go to APPLY, and on that same edge SHALL set idx=0, clear table_out to 0, clear ones_count to 0, and load the settle counter.
REQ-014 IDLE with start=0 SHALL hold all state; table_out and ones_count SHALL retain the results of the last scan.
REQ-015 The block SHALL remain in APPLY for exactly SETTLE_CYCLES cycles, using a settle counter, then go to SAMPLE.
REQ-016 SAMPLE SHALL last one cycle; on its exit edge table_out[idx] SHALL be set to f and ones_count SHALL be incremented by f.
REQ-017 On the SAMPLE exit edge, if idx<15 the block SHALL increment idx, reload the settle counter, and go to APPLY.
REQ-018 On the SAMPLE exit edge, if idx==15 the block SHALL go to DONE; idx SHALL NOT wrap to 0 and SHALL hold at 15.
REQ-019 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-020 busy SHALL be 1 in APPLY and SAMPLE, and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored in APPLY, SAMPLE and DONE; no restart or queuing SHALL occur.
REQ-022 If start is held high continuously, a new scan SHALL begin on the first IDLE edge after DONE.
REQ-023 Latency SHALL be as follows: the start edge is edge 0; done SHALL be high during cycle 16*(SETTLE_CYCLES+1); for the default, done SHALL be high in cycle 32 after the start edge.
REQ-024 ones_count SHALL never exceed 16 and SHALL equal the popcount of table_out at every edge.
REQ-025 The function stage SHALL be treated as purely combinational; no handshake SHALL be taken from it.

Reset
REQ-026 While rst=1, asynchronously: the state SHALL be IDLE, idx=0 (so a=b=c=d=0), the settle counter 0, busy=0, done=0, table_out=16'h0000 and ones_count=0.
REQ-027 Reset asserted mid-scan SHALL abort the scan, discard partial results, and produce no done pulse.
REQ-028 After reset deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-029 Connect the function stage f = ~((~a&b)|(b&c)) | (a&~d) | (b&d) with the default parameter and pulse start -> table_out=16'hFFAF, ones_count=14, done in cycle 32, busy high in cycles 1..31.
REQ-030 Tie f=0 and run a scan; then tie f=1 and run a scan -> first table_out=16'h0000 with ones_count=0; then table_out=16'hFFFF with ones_count=16 (no overflow).
REQ-031 Set SETTLE_CYCLES=3 and monitor {a,b,c,d} -> each idx is held for exactly 4 cycles, in order 0..15; done occurs in cycle 64.
REQ-032 Pulse start again at cycles 5 and 20 of a scan -> no effect; exactly one done pulse; results are identical to an undisturbed scan.
REQ-033 Assert rst at cycle 10 of a scan, then start again -> outputs return to reset values immediately, with no done; the second scan completes with correct results and no carry-over of partial results.
REQ-034 Hold start high for 70 cycles with the default parameter -> two back-to-back scans; done is seen in cycles 32 and 66; table_out is cleared at the start of the second scan.
